// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signals of sram_arbiter, bundled as one interface.
interface sram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_ack;
    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  sram_we_n;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_din;
    logic [DATA_WIDTH-1:0] sram_dout;

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, sram_dout,
        output a_ack, b_ack, rdata, busy, sram_we_n, sram_addr, sram_din
    );

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, sram_dout,
        input  a_ack, b_ack, rdata, busy, sram_we_n, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a read-only fetch
// port (A) and a load/store port (B), with setup/pulse/hold write sequencing.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int RD_CYCLES  = 1,
    parameter int WE_CYCLES  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_arbiter_if.slave  bus
);

    localparam int MAX_CYC = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]            state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  last_grant_r;   // 1 = port B won the previous grant
    logic                  grant_b_r;
    logic                  a_ack_r;
    logic                  b_ack_r;
    logic                  busy_r;
    logic                  we_n_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] din_r;
    logic [DATA_WIDTH-1:0] rdata_r;

    logic                  grant_valid_s;
    logic                  grant_b_s;
    logic                  grant_we_s;

    // Round-robin pick among the requests sampled in IDLE; a tie goes away from last_grant.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_b_s     = 1'b0;
        if (bus.a_req && bus.b_req) begin
            grant_valid_s = 1'b1;
            grant_b_s     = ~last_grant_r;
        end else if (bus.b_req) begin
            grant_valid_s = 1'b1;
            grant_b_s     = 1'b1;
        end else if (bus.a_req) begin
            grant_valid_s = 1'b1;
            grant_b_s     = 1'b0;
        end else begin
            grant_valid_s = 1'b0;
            grant_b_s     = 1'b0;
        end
    end

    assign grant_we_s = grant_b_s & bus.b_we;

    // Access sequencer: every SRAM-facing and requester-facing output is a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_grant_r <= 1'b0;
            grant_b_r    <= 1'b0;
            a_ack_r      <= 1'b0;
            b_ack_r      <= 1'b0;
            busy_r       <= 1'b0;
            we_n_r       <= 1'b1;
            addr_r       <= '0;
            din_r        <= '0;
            rdata_r      <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    we_n_r  <= 1'b1;
                    if (grant_valid_s) begin
                        grant_b_r    <= grant_b_s;
                        last_grant_r <= grant_b_s;
                        busy_r       <= 1'b1;
                        addr_r       <= grant_b_s ? bus.b_addr : bus.a_addr;
                        din_r        <= bus.b_wdata;
                        if (grant_we_s) begin
                            state_r <= ST_WR_SETUP;
                        end else begin
                            state_r <= ST_RD;
                            cnt_r   <= RD_LOAD;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (cnt_r == '0) begin
                        rdata_r <= bus.sram_dout;
                        a_ack_r <= ~grant_b_r;
                        b_ack_r <= grant_b_r;
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_WR_SETUP: begin
                    we_n_r  <= 1'b0;
                    cnt_r   <= WE_LOAD;
                    state_r <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt_r == '0) begin
                        we_n_r  <= 1'b1;
                        state_r <= ST_WR_HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_WR_HOLD: begin
                    a_ack_r <= ~grant_b_r;
                    b_ack_r <= grant_b_r;
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    // Requests are deliberately not looked at here; the requester is still dropping req.
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    a_ack_r <= 1'b0;
                    b_ack_r <= 1'b0;
                    busy_r  <= 1'b0;
                    we_n_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_ack     = a_ack_r;
    assign bus.b_ack     = b_ack_r;
    assign bus.rdata     = rdata_r;
    assign bus.busy      = busy_r;
    assign bus.sram_we_n = we_n_r;
    assign bus.sram_addr = addr_r;
    assign bus.sram_din  = din_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (RD/WE = 1/1 and 3/2) on behavioural SRAMs,
// checked against a transaction-level reference of memory, grants and latencies.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n_v;
    logic [1:0]       a_req_v, b_req_v, b_we_v;
    logic [1:0][15:0] a_addr_v, b_addr_v, b_wdata_v;
    logic [1:0]       a_ack_v, b_ack_v, busy_v, we_n_v;
    logic [1:0][15:0] rdata_v, sram_addr_v, sram_din_v;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          ref_last  [2];
    logic [15:0] ref_rdata [2];
    logic [15:0] ref_mem   [2][256];

    function automatic int rd_cyc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int we_cyc(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic [15:0] init_val(input int j);
        if (j == 16) return 16'hBEEF;
        return 16'((j * 257) ^ 32'h0000_3C5A);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        sram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
        logic [15:0] mem [256];
        logic        loaded = 1'b0;

        sram_arbiter #(
            .ADDR_WIDTH(16), .DATA_WIDTH(16),
            .RD_CYCLES((g == 0) ? 1 : 3), .WE_CYCLES((g == 0) ? 1 : 2)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n_v[g]),
            .bus  (bus)
        );

        assign bus.a_req      = a_req_v[g];
        assign bus.a_addr     = a_addr_v[g];
        assign bus.b_req      = b_req_v[g];
        assign bus.b_we       = b_we_v[g];
        assign bus.b_addr     = b_addr_v[g];
        assign bus.b_wdata    = b_wdata_v[g];
        assign a_ack_v[g]     = bus.a_ack;
        assign b_ack_v[g]     = bus.b_ack;
        assign busy_v[g]      = bus.busy;
        assign we_n_v[g]      = bus.sram_we_n;
        assign rdata_v[g]     = bus.rdata;
        assign sram_addr_v[g] = bus.sram_addr;
        assign sram_din_v[g]  = bus.sram_din;
        assign bus.sram_dout  = mem[bus.sram_addr[7:0]];

        // Asynchronous SRAM: preloaded once, then written whenever we_n is low.
        always @(negedge clk) begin
            if (!loaded) begin
                for (int j = 0; j < 256; j++) mem[j] <= init_val(j);
                loaded <= 1'b1;
            end else if (bus.sram_we_n === 1'b0) begin
                mem[bus.sram_addr[7:0]] <= bus.sram_din;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction; inputs are scrambled after the grant edge.
    task automatic do_op(input int i, input bit pb, input bit we,
                         input logic [15:0] addr, input logic [15:0] data);
        bit          is_wr;
        int          lat;
        logic [15:0] exp_rd;
        is_wr  = pb && we;
        lat    = is_wr ? we_cyc(i) + 3 : rd_cyc(i) + 1;
        exp_rd = ref_mem[i][addr[7:0]];
        @(negedge clk);
        if (pb) begin
            b_req_v[i] = 1'b1; b_we_v[i] = we; b_addr_v[i] = addr; b_wdata_v[i] = data;
        end else begin
            a_req_v[i] = 1'b1; a_addr_v[i] = addr;
        end
        @(posedge clk);
        ref_last[i] = pb;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b_we_v[i]    = ~b_we_v[i];
                b_addr_v[i]  = 16'($urandom);
                b_wdata_v[i] = 16'($urandom);
                a_addr_v[i]  = 16'($urandom);
                if ($urandom_range(0, 1) == 0) begin
                    a_req_v[i] = 1'b0; b_req_v[i] = 1'b0;
                end
            end
            chk("own_ack", 32'(pb ? b_ack_v[i] : a_ack_v[i]), 32'(k == lat));
            chk("other_ack", 32'(pb ? a_ack_v[i] : b_ack_v[i]), 32'd0);
            chk("busy", 32'(busy_v[i]), 32'd1);
            chk("we_n", 32'(we_n_v[i]), 32'(!(is_wr && k >= 2 && k <= we_cyc(i) + 1)));
            chk("sram_addr", 32'(sram_addr_v[i]), 32'(addr));
            if (is_wr) chk("sram_din", 32'(sram_din_v[i]), 32'(data));
            chk("rdata", 32'(rdata_v[i]), 32'((!is_wr && k == lat) ? exp_rd : ref_rdata[i]));
        end
        a_req_v[i] = 1'b0;
        b_req_v[i] = 1'b0;
        if (is_wr) ref_mem[i][addr[7:0]] = data;
        else       ref_rdata[i] = exp_rd;
        @(negedge clk);
        chk("idle_busy", 32'(busy_v[i]), 32'd0);
        chk("idle_acks", 32'({a_ack_v[i], b_ack_v[i]}), 32'd0);
        chk("idle_we_n", 32'(we_n_v[i]), 32'd1);
    endtask

    // Start an op, assert reset k_abort cycles after the grant, check immediate effect.
    task automatic abort_reset(input int i, input bit pb, input bit we,
                               input logic [15:0] addr, input int k_abort);
        @(negedge clk);
        if (pb) begin
            b_req_v[i] = 1'b1; b_we_v[i] = we; b_addr_v[i] = addr; b_wdata_v[i] = 16'($urandom);
        end else begin
            a_req_v[i] = 1'b1; a_addr_v[i] = addr;
        end
        @(posedge clk);
        for (int k = 1; k <= k_abort; k++) begin
            @(negedge clk);
            chk("abort_busy", 32'(busy_v[i]), 32'd1);
            chk("abort_we_n", 32'(we_n_v[i]), 32'(!(pb && we && k >= 2)));
        end
        rst_n_v[i] = 1'b0;
        #1;
        chk("rst_we_n", 32'(we_n_v[i]), 32'd1);
        chk("rst_acks", 32'({a_ack_v[i], b_ack_v[i]}), 32'd0);
        chk("rst_busy", 32'(busy_v[i]), 32'd0);
        chk("rst_rdata", 32'(rdata_v[i]), 32'd0);
        chk("rst_addr", 32'(sram_addr_v[i]), 32'd0);
        chk("rst_din", 32'(sram_din_v[i]), 32'd0);
        a_req_v[i] = 1'b0;
        b_req_v[i] = 1'b0;
        @(negedge clk);
        rst_n_v[i]   = 1'b1;
        ref_last[i]  = 1'b0;
        ref_rdata[i] = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_acks", 32'({a_ack_v[i], b_ack_v[i]}), 32'd0);
            chk("post_rst_busy", 32'(busy_v[i]), 32'd0);
            chk("post_rst_we_n", 32'(we_n_v[i]), 32'd1);
        end
    endtask

    // Both ports held: B writes addr, A reads it; grants alternate from B.
    task automatic contention(input int i, input logic [15:0] addr, input logic [15:0] data);
        int w;
        int lat;
        bit exp_b;
        bit seen;
        @(negedge clk);
        a_req_v[i] = 1'b1; a_addr_v[i] = addr;
        b_req_v[i] = 1'b1; b_we_v[i] = 1'b1; b_addr_v[i] = addr; b_wdata_v[i] = data;
        for (int n = 0; n < 4; n++) begin
            exp_b = !ref_last[i];
            lat   = exp_b ? we_cyc(i) + 3 : rd_cyc(i) + 1;
            if (n > 0) lat++;
            seen = 1'b0;
            w    = 0;
            while (!seen && w < 40) begin
                @(negedge clk);
                w++;
                chk("ack_overlap", 32'(a_ack_v[i] & b_ack_v[i]), 32'd0);
                if (a_ack_v[i] || b_ack_v[i]) seen = 1'b1;
            end
            chk("rr_ack_seen", 32'(seen), 32'd1);
            if (!seen) break;
            chk("rr_port_b", 32'(b_ack_v[i]), 32'(exp_b));
            chk("rr_spacing", 32'(w), 32'(lat));
            if (exp_b) begin
                ref_mem[i][addr[7:0]] = data;
            end else begin
                chk("rr_rdata", 32'(rdata_v[i]), 32'(ref_mem[i][addr[7:0]]));
                ref_rdata[i] = ref_mem[i][addr[7:0]];
            end
            ref_last[i] = exp_b;
        end
        a_req_v[i] = 1'b0;
        b_req_v[i] = 1'b0;
        repeat (2) @(negedge clk);
        chk("rr_end_busy", 32'(busy_v[i]), 32'd0);
    endtask

    // Long read on A with B arriving mid-read: B waits for IDLE after A's DONE.
    task automatic mid_read(input int i, input logic [15:0] aaddr, input logic [15:0] baddr);
        int ka;
        int kb;
        ka = rd_cyc(i) + 1;
        kb = 2 * rd_cyc(i) + 3;
        @(negedge clk);
        a_req_v[i] = 1'b1; a_addr_v[i] = aaddr;
        @(posedge clk);
        for (int k = 1; k <= kb; k++) begin
            @(negedge clk);
            if (k == 2) begin
                b_req_v[i] = 1'b1; b_we_v[i] = 1'b0; b_addr_v[i] = baddr;
            end
            chk("mid_a_ack", 32'(a_ack_v[i]), 32'(k == ka));
            chk("mid_b_ack", 32'(b_ack_v[i]), 32'(k == kb));
            if (k == ka) begin
                a_req_v[i] = 1'b0;
                chk("mid_a_rdata", 32'(rdata_v[i]), 32'(ref_mem[i][aaddr[7:0]]));
            end
            if (k == kb) begin
                b_req_v[i] = 1'b0;
                chk("mid_b_rdata", 32'(rdata_v[i]), 32'(ref_mem[i][baddr[7:0]]));
            end
        end
        ref_rdata[i] = ref_mem[i][baddr[7:0]];
        ref_last[i]  = 1'b1;
        @(negedge clk);
        chk("mid_end_busy", 32'(busy_v[i]), 32'd0);
    endtask

    initial begin
        rst_n_v   = 2'b00;
        a_req_v   = 2'b00;
        b_req_v   = 2'b00;
        b_we_v    = 2'b00;
        a_addr_v  = '0;
        b_addr_v  = '0;
        b_wdata_v = '0;
        for (int i = 0; i < 2; i++) begin
            ref_last[i]  = 1'b0;
            ref_rdata[i] = 16'h0000;
            for (int j = 0; j < 256; j++) ref_mem[i][j] = init_val(j);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_we_n", 32'(we_n_v[i]), 32'd1);
            chk("reset_busy", 32'(busy_v[i]), 32'd0);
            chk("reset_acks", 32'({a_ack_v[i], b_ack_v[i]}), 32'd0);
            chk("reset_rdata", 32'(rdata_v[i]), 32'd0);
            chk("reset_addr", 32'(sram_addr_v[i]), 32'd0);
        end
        rst_n_v = 2'b11;

        do_op(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        do_op(0, 1'b1, 1'b1, 16'h0020, 16'h1234);
        do_op(0, 1'b0, 1'b0, 16'h0020, 16'h0000);

        mid_read(1, 16'h0010, 16'h0005);
        abort_reset(1, 1'b1, 1'b1, 16'h00AA, 2);
        do_op(1, 1'b1, 1'b1, 16'h0003, 16'hC0DE);
        do_op(1, 1'b0, 1'b0, 16'h0003, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] addr;
            addr = (n % 8 == 7) ? 16'hFFFF : 16'($urandom_range(0, 31));
            do_op(n % 2, 1'($urandom), 1'($urandom), addr, 16'($urandom));
        end

        abort_reset(0, 1'b0, 1'b0, 16'h0007, 1);
        contention(0, 16'h0011, 16'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
